phy_rx_deser_lane: RTL and testbench

- Single-lane receive deserializer. It sits directly downstream of one serial lane output of phy_tx, e.g. salida_ser_lane_0_cond.
- Samples the serial bit stream on clk_8f and finds byte alignment by detecting the COM character that the transmitter sends on idle.
- After LOCK_COUNT consecutive aligned COMs, emits recovered bytes with a valid flag, restoring the validin/entrada pairing seen at the phy_tx input.
- Two instances (lane 0, lane 1) form the phy_rx front end.

---
 rtl/phy_rx_deser_lane.sv | 137 +++++++++++++
 tb/tb_phy_rx_deser_lane.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deser_lane.sv
// phy_rx_deser_lane
//   Single-lane receive deserializer. Shifts the serial lane in MSB first on
//   clk_8f, slides across bit positions until the idle COM character appears,
//   then confirms the byte phase with LOCK_COUNT consecutive COMs before
//   emitting recovered bytes once per 8 bit times.
//
// Ports
//   clk_8f    in   bit clock, one serial bit per rising edge
//   reset     in   asynchronous active-low reset
//   enable    in   synchronous enable; low drops back to SEARCH, clears flags
//   serial_in in   serial lane data, MSB first
//   data_out  out  [7:0] last recovered byte (held between strobes)
//   valid_out out  data_out is a data byte, not COM_CHAR (sticky)
//   byte_stb  out  one-cycle pulse per emitted byte while locked
//   active    out  lane aligned and locked
module phy_rx_deser_lane #(
  parameter logic [7:0]  COM_CHAR   = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  // com_cnt+1 == LOCK_COUNT is evaluated as com_cnt == LOCK_COUNT-1
  localparam logic [3:0] LOCK_M1 = 4'(LOCK_COUNT - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_sr, w_sr_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0] r_com_cnt, w_com_cnt_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_stb, w_stb_nxt;
  logic       r_active, w_active_nxt;

  logic       w_is_com;
  logic       w_bnd;

  assign w_is_com = (r_sr == COM_CHAR);
  // bit_cnt wraps to 0 exactly when sr holds a full byte in the locked phase
  assign w_bnd    = (r_bit_cnt == 3'd0);

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      r_state   <= SEARCH;
      r_sr      <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= 4'd0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_stb     <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_com_cnt <= w_com_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_stb     <= w_stb_nxt;
      r_active  <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_bit_cnt_nxt = r_bit_cnt;
    w_com_cnt_nxt = r_com_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_stb_nxt     = 1'b0;
    w_active_nxt  = r_active;

    if (!enable) begin
      // sr and bit_cnt freeze; data_out keeps the last byte
      w_state_nxt   = SEARCH;
      w_com_cnt_nxt = 4'd0;
      w_valid_nxt   = 1'b0;
      w_active_nxt  = 1'b0;
    end else begin
      w_sr_nxt      = {r_sr[6:0], serial_in};
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      case (r_state)
        SEARCH: begin
          // sliding match: bit_cnt restarts so the next boundary is 8 edges out
          if (w_is_com) begin
            w_bit_cnt_nxt = 3'd1;
            w_com_cnt_nxt = 4'd1;
            if (LOCK_COUNT == 1) begin
              w_state_nxt  = LOCKED;
              w_active_nxt = 1'b1;
            end else begin
              w_state_nxt  = ALIGN;
            end
          end
        end
        ALIGN: begin
          if (w_bnd) begin
            if (w_is_com && (r_com_cnt == LOCK_M1)) begin
              w_state_nxt  = LOCKED;
              w_active_nxt = 1'b1;
            end else if (w_is_com) begin
              w_com_cnt_nxt = r_com_cnt + 4'd1;
            end else begin
              w_state_nxt   = SEARCH;
              w_com_cnt_nxt = 4'd0;
            end
          end
        end
        LOCKED: begin
          // no lock-loss detection; only reset or enable=0 leave LOCKED
          if (w_bnd) begin
            w_data_nxt  = r_sr;
            w_valid_nxt = !w_is_com;
            w_stb_nxt   = 1'b1;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign byte_stb  = r_stb;
  assign active    = r_active;

endmodule

// File: tb/tb_phy_rx_deser_lane.sv
// tb_phy_rx_deser_lane
//   Two lanes: lane 0 with LOCK_COUNT=4, lane 1 with LOCK_COUNT=1. A
//   bit-history reference model (per-lane array of received bits, alignment
//   tracked as edges-since-detection modulo 8) predicts every output on every
//   cycle; directed segments add constant expectations on recovered bytes.
module tb_phy_rx_deser_lane;

  localparam logic [7:0] COM = 8'hBC;
  localparam int LK0 = 4;
  localparam int LK1 = 1;

  logic            clk_8f = 1'b0;
  logic            reset  = 1'b0;
  logic            enable = 1'b1;
  logic [1:0]      sin    = 2'b00;
  logic [1:0][7:0] dout;
  logic [1:0]      vout, stb, act;

  phy_rx_deser_lane #(.COM_CHAR(COM), .LOCK_COUNT(LK0)) u_lane0 (
    .clk_8f(clk_8f), .reset(reset), .enable(enable), .serial_in(sin[0]),
    .data_out(dout[0]), .valid_out(vout[0]), .byte_stb(stb[0]), .active(act[0]));

  phy_rx_deser_lane #(.COM_CHAR(COM), .LOCK_COUNT(LK1)) u_lane1 (
    .clk_8f(clk_8f), .reset(reset), .enable(enable), .serial_in(sin[1]),
    .data_out(dout[1]), .valid_out(vout[1]), .byte_stb(stb[1]), .active(act[1]));

  always #5 clk_8f = ~clk_8f;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // reference model state
  bit         hist [2][8192];
  int         hcnt [2];
  int         m_mode [2];   // 0 search, 1 align, 2 locked
  int         m_since [2];  // edges since the COM detection edge
  int         m_coms [2];
  logic [7:0] m_data [2];
  logic       m_valid [2], m_stb [2], m_act [2];

  logic [8:0] cap0 [$];
  logic [8:0] cap1 [$];
  int         capt0 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int lk(input int l);
    return (l == 0) ? LK0 : LK1;
  endfunction

  function automatic logic [7:0] window(input int l);
    logic [7:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      idx = hcnt[l] - 8 + k;
      if (idx >= 0) w[7-k] = hist[l][idx];
    end
    return w;
  endfunction

  task automatic model_reset(input int l);
    hcnt[l] = 0; m_mode[l] = 0; m_since[l] = 0; m_coms[l] = 0;
    m_data[l] = 8'h00; m_valid[l] = 1'b0; m_stb[l] = 1'b0; m_act[l] = 1'b0;
  endtask

  task automatic model_edge(input int l, input bit b, input bit en);
    logic [7:0] w;
    w = window(l);
    m_stb[l] = 1'b0;
    if (!en) begin
      m_mode[l] = 0; m_coms[l] = 0; m_act[l] = 1'b0; m_valid[l] = 1'b0;
    end else begin
      if (m_mode[l] != 0) m_since[l]++;
      case (m_mode[l])
        0: if (w == COM) begin
             m_since[l] = 0;
             if (lk(l) == 1) begin m_mode[l] = 2; m_act[l] = 1'b1; end
             else begin m_mode[l] = 1; m_coms[l] = 1; end
           end
        1: if (m_since[l] % 8 == 0) begin
             if (w == COM && m_coms[l] + 1 == lk(l)) begin m_mode[l] = 2; m_act[l] = 1'b1; end
             else if (w == COM) m_coms[l]++;
             else begin m_mode[l] = 0; m_coms[l] = 0; end
           end
        default: if (m_since[l] % 8 == 0) begin
             m_data[l] = w; m_valid[l] = (w != COM); m_stb[l] = 1'b1;
           end
      endcase
      if (hcnt[l] < 8192) begin hist[l][hcnt[l]] = b; hcnt[l]++; end
    end
  endtask

  task automatic step(input logic b0, input logic b1, input logic en);
    sin[0] = b0; sin[1] = b1; enable = en;
    @(posedge clk_8f);
    for (int l = 0; l < 2; l++) begin
      if (!reset) model_reset(l);
      else if (l == 0) model_edge(0, b0, en);
      else model_edge(1, b1, en);
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d data", l), dout[l], m_data[l]);
      chk($sformatf("L%0d valid", l), vout[l], m_valid[l]);
      chk($sformatf("L%0d stb", l), stb[l], m_stb[l]);
      chk($sformatf("L%0d active", l), act[l], m_act[l]);
    end
    if (stb[0]) begin cap0.push_back({vout[0], dout[0]}); capt0.push_back(cyc); end
    if (stb[1]) cap1.push_back({vout[1], dout[1]});
    cyc++;
  endtask

  task automatic send2(input logic [7:0] d0, input logic [7:0] d1);
    for (int i = 7; i >= 0; i--) step(d0[i], d1[i], 1'b1);
  endtask

  task automatic send(input logic [7:0] d);
    send2(d, d);
  endtask

  task automatic rst_pulse();
    #2 reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r0, r1;
    int nv;
    model_reset(0); model_reset(1);

    // reset held, then a constant-1 stream never aligns
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    chk("rst data", dout[0], 8'h00);
    chk("rst valid", vout[0], 1'b0);
    chk("rst active", act[0], 1'b0);
    reset = 1'b1;
    cap0.delete(); cap1.delete();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1);
    chk("ff stbs", cap0.size(), 0);
    chk("ff active", act[0], 1'b0);
    chk("ff data", dout[0], 8'h00);

    // garbage 101, 4 COMs, then data
    cap0.delete(); capt0.delete();
    step(1'b1, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(COM);
    chk("prelock active", act[0], 1'b0);
    send(8'h01);
    chk("lock active", act[0], 1'b1);
    chk("lock no stb yet", cap0.size(), 0);
    send(8'h02); send(COM); send(COM);
    chk("seq count", cap0.size(), 3);
    if (cap0.size() == 3) begin
      chk("seq b0", cap0[0], 9'h101);
      chk("seq b1", cap0[1], 9'h102);
      chk("seq b2", cap0[2], 9'h0BC);
      chk("stb gap0", capt0[1] - capt0[0], 8);
      chk("stb gap1", capt0[2] - capt0[1], 8);
    end

    // broken COM run: 0x55 restarts the count
    rst_pulse();
    cap0.delete();
    send(COM); send(COM); send(8'h55);
    for (int i = 0; i < 4; i++) send(COM);
    chk("brk active", act[0], 1'b0);
    chk("brk no stb", cap0.size(), 0);
    send(8'h33);
    chk("brk lock", act[0], 1'b1);
    send(8'h44);
    chk("brk count", cap0.size(), 1);
    if (cap0.size() == 1) chk("brk byte", cap0[0], 9'h133);

    // enable low for 5 cycles mid-byte of 0xF0
    for (int i = 7; i >= 5; i--) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("en active", act[0], 1'b0);
    chk("en valid", vout[0], 1'b0);
    chk("en data hold", dout[0], 8'h44);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("en data hold2", dout[0], 8'h44);
    cap0.delete();
    for (int i = 0; i < 4; i++) send(COM);
    send(8'h5A); send(8'h00);
    chk("relock count", cap0.size(), 1);
    if (cap0.size() == 1) chk("relock byte", cap0[0], 9'h15A);

    // async reset between edges while locked
    send(8'hEF);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    #3 reset = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("arst L%0d data", l), dout[l], 8'h00);
      chk($sformatf("arst L%0d valid", l), vout[l], 1'b0);
      chk($sformatf("arst L%0d stb", l), stb[l], 1'b0);
      chk($sformatf("arst L%0d active", l), act[l], 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    cap0.delete();
    for (int i = 0; i < 4; i++) send(COM);
    send(8'hF1); send(8'h00);
    chk("arst relock data", dout[0], 8'hF1);
    chk("arst relock valid", vout[0], 1'b1);
    chk("arst relock count", cap0.size(), 1);

    // two serializer lanes: COM when idle, data when valid
    rst_pulse();
    cap0.delete(); cap1.delete();
    for (int i = 0; i < 5; i++) send(COM);
    send2(8'h01, 8'hF0); send2(8'h02, 8'hF1); send2(8'h03, 8'hF2); send2(8'h04, COM);
    for (int i = 0; i < 3; i++) send(COM);
    nv = 0;
    foreach (cap0[k]) begin
      if (cap0[k][8]) begin
        chk("lane0 byte", cap0[k][7:0], 8'(nv + 1));
        nv++;
      end else chk("lane0 idle", cap0[k][7:0], COM);
    end
    chk("lane0 nbytes", nv, 4);
    nv = 0;
    foreach (cap1[k]) begin
      if (cap1[k][8]) begin
        chk("lane1 byte", cap1[k][7:0], 8'hF0 + 8'(nv));
        nv++;
      end else chk("lane1 idle", cap1[k][7:0], COM);
    end
    chk("lane1 nbytes", nv, 3);

    // randomized traffic with slips and enable drops, model-checked per cycle
    rst_pulse();
    for (int n = 0; n < 200; n++) begin
      r0 = ($urandom % 2 == 0) ? COM : 8'($urandom);
      r1 = ($urandom % 2 == 0) ? COM : 8'($urandom);
      if ($urandom % 16 == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 6)); i++)
          step(1'($urandom), 1'($urandom), 1'b0);
      end
      if ($urandom % 20 == 0) step(1'($urandom), 1'($urandom), 1'b1);
      send2(r0, r1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
